// File: rtl/llm_pkg.sv
// ---------------------------------------------------------------------------
// llm_pkg
// Shared types and constants for the intrusion-agent stage FSM.
//   state_e      : 4-bit state code (LAY_LOW=0, DECEPTION=1, ATTACK=2,
//                  FAIL=4, EXPANSION=5)
//   DCNT_W/MAX   : deception counter width and saturation value
//   stage_dwell(): minimum dwell timer value for attack stage k
// ---------------------------------------------------------------------------
package llm_pkg;

   typedef enum logic [3:0] {
      ST_LAY_LOW   = 4'd0,
      ST_DECEPTION = 4'd1,
      ST_ATTACK    = 4'd2,
      ST_FAIL      = 4'd4,
      ST_EXPANSION = 4'd5
   } state_e;

   localparam int          DCNT_W   = 4;
   localparam logic [3:0]  DCNT_MAX = 4'hF;

   // The last stage uses the shorter final dwell before EXPANSION.
   function automatic int stage_dwell(input logic [2:0] k,
                                      input int num_stages,
                                      input int stage_dw,
                                      input int final_dw);
      return (int'(k) == num_stages - 1) ? final_dw : stage_dw;
   endfunction

endpackage

// File: rtl/llm_sat_timer.sv
// ---------------------------------------------------------------------------
// llm_sat_timer
// Saturating dwell timer. Load forces the count to 1; otherwise the count
// increments when enabled and sticks at all-ones instead of wrapping.
// Ports:
//   i_clk  : rising-edge clock
//   i_load : load 1 (has priority over increment)
//   i_inc  : increment enable
//   o_q    : current count
// ---------------------------------------------------------------------------
module llm_sat_timer #(
   parameter int TIMER_W = 6
) (
   input  logic               i_clk,
   input  logic               i_load,
   input  logic               i_inc,
   output logic [TIMER_W-1:0] o_q
);

   localparam logic [TIMER_W-1:0] TMAX = '1;

   logic [TIMER_W-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_load)
         r_q <= TIMER_W'(1);
      else if (i_inc && (r_q != TMAX))
         r_q <= r_q + 1'b1;
   end

   assign o_q = r_q;

endmodule

// File: rtl/llm_stage_fsm.sv
// ---------------------------------------------------------------------------
// llm_stage_fsm
// Intrusion-agent FSM with NUM_STAGES attack stages, a deception window with
// a limited budget, and terminal FAIL / EXPANSION states. All outputs are
// registered; a transition is visible the cycle after its sampling edge.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   green/red/yellow    : advance / threat / retreat (red > yellow > green)
//   attack              : thermometer of engaged stages
//   expansion_out       : high in EXPANSION
//   deception_out       : high in DECEPTION
//   fail_out            : high in FAIL
//   current_state       : 4-bit state code
//   stage_idx           : current / last attack stage
//   timer               : cycles in current state (starts at 1, saturates)
//   deception_count     : DECEPTION entries since reset (saturates at 15)
// Optional build macro:
//   LLM_EXPANSION_ABORT_EN : red in EXPANSION re-enters DECEPTION
// ---------------------------------------------------------------------------
module llm_stage_fsm
   import llm_pkg::*;
#(
   parameter int NUM_STAGES        = 2,
   parameter int TIMER_W           = 6,
   parameter int LAY_LOW_DWELL     = 20,
   parameter int STAGE_DWELL       = 20,
   parameter int FINAL_STAGE_DWELL = 10,
   parameter int DECEPTION_LEN     = 15,
   parameter int MAX_DECEPTIONS    = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  green,
   input  logic                  red,
   input  logic                  yellow,
   output logic [NUM_STAGES-1:0] attack,
   output logic                  expansion_out,
   output logic                  deception_out,
   output logic                  fail_out,
   output logic [3:0]            current_state,
   output logic [2:0]            stage_idx,
   output logic [TIMER_W-1:0]    timer,
   output logic [3:0]            deception_count
);

   state_e                r_state;
   logic [2:0]            r_stage;
   logic [NUM_STAGES-1:0] r_attack;
   logic                  r_exp;
   logic                  r_dec;
   logic                  r_fail;
   logic [DCNT_W-1:0]     r_dcnt;

   logic [TIMER_W-1:0]    w_timer;
   logic [31:0]           w_t32;
   logic                  w_last;
   logic                  w_ll_ok;
   logic                  w_dwell_ok;
   logic                  w_dec_done;
   logic                  w_budget_out;
   logic [DCNT_W-1:0]     w_dcnt_inc;
   logic [NUM_STAGES-1:0] w_bit_cur;
   logic [NUM_STAGES-1:0] w_bit_nxt;
   logic                  w_change;
   logic                  w_tload;
   logic                  w_tinc;

   assign w_t32        = 32'(w_timer);
   assign w_last       = (32'(r_stage) == 32'(NUM_STAGES - 1));
   assign w_ll_ok      = (w_t32 >= 32'(LAY_LOW_DWELL));
   assign w_dwell_ok   = (w_t32 >= 32'(stage_dwell(r_stage, NUM_STAGES,
                                                   STAGE_DWELL, FINAL_STAGE_DWELL)));
   assign w_dec_done   = (w_t32 >= 32'(DECEPTION_LEN));
   assign w_budget_out = (32'(r_dcnt) >= 32'(MAX_DECEPTIONS));
   assign w_dcnt_inc   = (r_dcnt == DCNT_MAX) ? r_dcnt : r_dcnt + 1'b1;
   assign w_bit_cur    = NUM_STAGES'(1) << r_stage;
   assign w_bit_nxt    = NUM_STAGES'(1) << (r_stage + 3'd1);

   // Any state or stage change reloads the timer; this mirrors the
   // transition conditions of the state register below.
   always_comb begin
      w_change = 1'b0;
      case (r_state)
         ST_LAY_LOW:   w_change = red | (!yellow & green & w_ll_ok);
         ST_ATTACK:    w_change = red | yellow | (green & w_dwell_ok);
         ST_DECEPTION: w_change = w_dec_done;
         ST_FAIL:      w_change = 1'b0;
`ifdef LLM_EXPANSION_ABORT_EN
         ST_EXPANSION: w_change = red;
`else
         ST_EXPANSION: w_change = 1'b0;
`endif
         default:      w_change = 1'b1;
      endcase
   end

   assign w_tload = reset | w_change;
   // FAIL freezes the timer at the 1 it was loaded with on entry.
   assign w_tinc  = (r_state != ST_FAIL);

   llm_sat_timer #(.TIMER_W(TIMER_W)) u_timer (
      .i_clk  (clock),
      .i_load (w_tload),
      .i_inc  (w_tinc),
      .o_q    (w_timer)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= ST_LAY_LOW;
         r_stage  <= 3'd0;
         r_attack <= '0;
         r_exp    <= 1'b0;
         r_dec    <= 1'b0;
         r_fail   <= 1'b0;
         r_dcnt   <= '0;
      end else begin
         case (r_state)
            ST_LAY_LOW: begin
               if (red) begin
                  r_state <= ST_DECEPTION;
                  r_dec   <= 1'b1;
                  r_dcnt  <= w_dcnt_inc;
               end else if (!yellow && green && w_ll_ok) begin
                  r_state  <= ST_ATTACK;
                  r_stage  <= 3'd0;
                  r_attack <= NUM_STAGES'(1);
               end
            end

            ST_ATTACK: begin
               if (red) begin
                  // attack bits and stage index survive into DECEPTION
                  r_state <= ST_DECEPTION;
                  r_dec   <= 1'b1;
                  r_dcnt  <= w_dcnt_inc;
               end else if (yellow) begin
                  if (r_stage == 3'd0) begin
                     r_state  <= ST_LAY_LOW;
                     r_attack <= '0;
                  end else begin
                     r_attack <= r_attack & ~w_bit_cur;
                     r_stage  <= r_stage - 3'd1;
                  end
               end else if (green && w_dwell_ok) begin
                  if (!w_last) begin
                     r_stage  <= r_stage + 3'd1;
                     r_attack <= r_attack | w_bit_nxt;
                  end else begin
                     r_state <= ST_EXPANSION;
                     r_exp   <= 1'b1;
                  end
               end
            end

            ST_DECEPTION: begin
               // inputs are ignored until the window closes
               if (w_dec_done) begin
                  r_attack <= '0;
                  r_stage  <= 3'd0;
                  r_dec    <= 1'b0;
                  r_exp    <= 1'b0;
                  if (red || w_budget_out) begin
                     r_state <= ST_FAIL;
                     r_fail  <= 1'b1;
                  end else begin
                     r_state <= ST_LAY_LOW;
                  end
               end
            end

            ST_FAIL: begin
               r_attack <= '0;
               r_stage  <= 3'd0;
               r_exp    <= 1'b0;
               r_dec    <= 1'b0;
               r_fail   <= 1'b1;
            end

            ST_EXPANSION: begin
`ifdef LLM_EXPANSION_ABORT_EN
               if (red) begin
                  r_state <= ST_DECEPTION;
                  r_exp   <= 1'b0;
                  r_dec   <= 1'b1;
                  r_dcnt  <= w_dcnt_inc;
               end
`endif
            end

            default: begin
               // unreachable codes recover to reset values; budget is kept
               r_state  <= ST_LAY_LOW;
               r_stage  <= 3'd0;
               r_attack <= '0;
               r_exp    <= 1'b0;
               r_dec    <= 1'b0;
               r_fail   <= 1'b0;
            end
         endcase
      end
   end

   assign attack          = r_attack;
   assign expansion_out   = r_exp;
   assign deception_out   = r_dec;
   assign fail_out        = r_fail;
   assign current_state   = r_state;
   assign stage_idx       = r_stage;
   assign timer           = w_timer;
   assign deception_count = r_dcnt;

endmodule

// File: tb/tb_llm_stage_fsm.sv
// ---------------------------------------------------------------------------
// tb_llm_stage_fsm
// Two instances share stimulus: NUM_STAGES=3 with TIMER_W=6, and NUM_STAGES=3
// with TIMER_W=4 (timer saturation). A behavioural model predicts every
// cycle's outputs into per-instance queues; a monitor compares them.
// ---------------------------------------------------------------------------
module tb_llm_stage_fsm;

   localparam int NS = 3;

   logic clock, reset, green, red, yellow;

   logic [NS-1:0] a6, a4;
   logic          x6, x4, d6, d4, f6, f4;
   logic [3:0]    s6, s4, c6, c4;
   logic [2:0]    k6, k4;
   logic [5:0]    t6;
   logic [3:0]    t4;

   llm_stage_fsm #(.NUM_STAGES(NS), .TIMER_W(6)) u_dut (
      .clock(clock), .reset(reset), .green(green), .red(red), .yellow(yellow),
      .attack(a6), .expansion_out(x6), .deception_out(d6), .fail_out(f6),
      .current_state(s6), .stage_idx(k6), .timer(t6), .deception_count(c6));

   llm_stage_fsm #(.NUM_STAGES(NS), .TIMER_W(4)) u_dut4 (
      .clock(clock), .reset(reset), .green(green), .red(red), .yellow(yellow),
      .attack(a4), .expansion_out(x4), .deception_out(d4), .fail_out(f4),
      .current_state(s4), .stage_idx(k4), .timer(t4), .deception_count(c4));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct { int st; int stage; int attack; int timer; int dcnt; } mdl_t;
   typedef struct { int st; int stage; int attack; int xo; int dco; int fo; int timer; int dcnt; } exp_t;

   mdl_t m6, m4;
   exp_t q6[$];
   exp_t q4[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   // Spec-level rules: modes LAY_LOW=0, DECEPTION=1, ATTACK=2, FAIL=4, EXPANSION=5.
   function automatic mdl_t mstep(mdl_t m, bit r, bit y, bit g, bit rs, int tw);
      mdl_t n = m;
      bit   moved = 0;
      int   dw;
      int   tmax = (1 << tw) - 1;
      if (rs) begin
         n.st = 0; n.stage = 0; n.attack = 0; n.timer = 1; n.dcnt = 0;
         return n;
      end
      case (m.st)
         0: begin
            if (r) begin n.st = 1; n.dcnt = (m.dcnt < 15) ? m.dcnt + 1 : 15; moved = 1; end
            else if (!y && g && m.timer >= 20) begin n.st = 2; n.stage = 0; n.attack = 1; moved = 1; end
         end
         2: begin
            dw = (m.stage == NS - 1) ? 10 : 20;
            if (r) begin n.st = 1; n.dcnt = (m.dcnt < 15) ? m.dcnt + 1 : 15; moved = 1; end
            else if (y) begin
               moved = 1;
               if (m.stage == 0) begin n.st = 0; n.attack = 0; end
               else begin n.attack = m.attack & ~(1 << m.stage); n.stage = m.stage - 1; end
            end else if (g && m.timer >= dw) begin
               moved = 1;
               if (m.stage < NS - 1) begin n.stage = m.stage + 1; n.attack = m.attack | (1 << n.stage); end
               else n.st = 5;
            end
         end
         1: begin
            if (m.timer >= 15) begin
               moved = 1; n.attack = 0; n.stage = 0;
               n.st = (r || m.dcnt >= 3) ? 4 : 0;
            end
         end
         5: begin
`ifdef LLM_EXPANSION_ABORT_EN
            if (r) begin n.st = 1; n.dcnt = (m.dcnt < 15) ? m.dcnt + 1 : 15; moved = 1; end
`endif
         end
         default: ;
      endcase
      if (moved) n.timer = 1;
      else if (m.st != 4) n.timer = (m.timer < tmax) ? m.timer + 1 : tmax;
      return n;
   endfunction

   function automatic exp_t outs(mdl_t m);
      exp_t e;
      e.st = m.st; e.stage = m.stage; e.attack = m.attack; e.timer = m.timer; e.dcnt = m.dcnt;
      e.xo = (m.st == 5) ? 1 : 0;
      e.dco = (m.st == 1) ? 1 : 0;
      e.fo = (m.st == 4) ? 1 : 0;
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, req);
      end
   endtask

   // Drive one cycle of inputs and queue the model's prediction for it.
   task automatic step(input bit r, input bit y, input bit g, input bit rs);
      @(negedge clock);
      red = r; yellow = y; green = g; reset = rs;
      m6 = mstep(m6, r, y, g, rs, 6);
      m4 = mstep(m4, r, y, g, rs, 4);
      q6.push_back(outs(m6));
      q4.push_back(outs(m4));
   endtask

   task automatic rep(input int n, input bit r, input bit y, input bit g);
      for (int i = 0; i < n; i++) step(r, y, g, 1'b0);
   endtask

   task automatic do_reset();
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
   endtask

   // Monitor: every cycle the DUT presents a new registered output set.
   always @(posedge clock) begin
      exp_t e;
      #1;
      cyc++;
      if (q6.size() > 0) begin
         e = q6.pop_front();
         chk("w6.state", int'(s6), e.st);
         chk("w6.stage", int'(k6), e.stage);
         chk("w6.attack", int'(a6), e.attack);
         chk("w6.expansion", int'(x6), e.xo);
         chk("w6.deception", int'(d6), e.dco);
         chk("w6.fail", int'(f6), e.fo);
         chk("w6.timer", int'(t6), e.timer);
         chk("w6.dcount", int'(c6), e.dcnt);
      end
      if (q4.size() > 0) begin
         e = q4.pop_front();
         chk("w4.state", int'(s4), e.st);
         chk("w4.attack", int'(a4), e.attack);
         chk("w4.fail", int'(f4), e.fo);
         chk("w4.deception", int'(d4), e.dco);
         chk("w4.timer", int'(t4), e.timer);
         chk("w4.dcount", int'(c4), e.dcnt);
      end
   end

   initial begin
      red = 0; yellow = 0; green = 0; reset = 1;
      m6 = '{default: 0}; m4 = '{default: 0};

      // Green held from reset release: ATTACK@20, stage1@40, stage2@60, EXPANSION@70.
      do_reset();
      rep(75, 0, 0, 1);
      @(posedge clock); #2;
      chk("dir.exp_state", int'(s6), 5);
      chk("dir.exp_attack", int'(a6), 7);
      chk("dir.exp_out", int'(x6), 1);
      rep(1, 1, 0, 0);
      rep(20, 0, 0, 0);

      // Stage 1 for 5 cycles, then two yellow pulses.
      do_reset();
      rep(45, 0, 0, 1);
      rep(1, 0, 1, 0);
      rep(1, 0, 1, 0);
      rep(5, 0, 0, 0);

      // Red pulse in stage 0, window runs out, back to LAY_LOW.
      do_reset();
      rep(25, 0, 0, 1);
      rep(1, 1, 0, 0);
      rep(20, 0, 0, 0);

      // Red held through the window: terminal until reset.
      do_reset();
      rep(20, 1, 0, 0);
      @(posedge clock); #2;
      chk("dir.held_fail", int'(f6), 1);
      chk("dir.held_attack", int'(a6), 0);
      rep(10, 0, 0, 1);

      // Budget: third deception ends in the terminal state.
      do_reset();
      for (int p = 0; p < 3; p++) begin
         rep(1, 1, 0, 0);
         rep(20, 0, 0, 0);
      end
      @(posedge clock); #2;
      chk("dir.budget_fail", int'(f6), 1);
      chk("dir.budget_count", int'(c6), 3);

      // Idle LAY_LOW: 4-bit timer saturates at 15.
      do_reset();
      rep(30, 0, 0, 0);
      @(posedge clock); #2;
      chk("dir.sat_timer4", int'(t4), 15);

      // Reset mid-deception.
      do_reset();
      rep(1, 1, 0, 0);
      rep(7, 0, 0, 0);
      step(0, 0, 0, 1);
      rep(3, 0, 0, 0);

      // Randomized episodes, green-biased with occasional yellow/red.
      for (int ep = 0; ep < 20; ep++) begin
         do_reset();
         for (int i = 0; i < 110; i++) begin
            bit r, y, g;
            r = ($urandom_range(0, 59) == 0);
            y = ($urandom_range(0, 24) == 0);
            g = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) step(r, y, g, 1'b1);
            else step(r, y, g, 1'b0);
         end
      end

      rep(2, 0, 0, 0);
      repeat (3) @(posedge clock);
      #2;
      if (q6.size() != 0 || q4.size() != 0) begin
         n_chk++; n_fail++;
         $display("FAIL drain q6=%0d q4=%0d expected=0", q6.size(), q4.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
